seg7_scan_display: RTL and testbench

//  Parametrised time-multiplexed hex display driver for N seven-segment digits. Replaces fixed
//  two-group 4-digit display logic at top level; shows datapath values (e.g. v0/v1 halves).

---
 rtl/seg7_scan_display_pkg.sv | 50 +++++
 rtl/seg7_scan_display_if.sv | 18 +
 rtl/seg7_scan_display_hex_decoder.sv | 9 +
 rtl/seg7_scan_display.sv | 119 +++++++++++
 tb/tb_seg7_scan_display.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_display_pkg.sv
// Shared definitions for the scanned seven-segment driver: hex segment table,
// pin polarity helpers and the digit index width.
package seg7_scan_display_pkg;

    // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    function automatic logic off_level(input int active_low);
        return (active_low != 0);
    endfunction

    function automatic logic on_level(input int active_low);
        return (active_low == 0);
    endfunction

    function automatic logic [6:0] seg_off(input int active_low);
        return {7{off_level(active_low)}};
    endfunction

    function automatic logic [6:0] seg_on(input int active_low);
        return {7{on_level(active_low)}};
    endfunction

    // At least one bit so a single-digit build still has a legal index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Value/control inputs and pin outputs of the scanned display, bundled for port lists.
interface seg7_scan_display_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic [6:0]              out7;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   en_out;
  logic                    frame_done;

  modport master (output enable, value, dp_in, load,
                  input  out7, dp_out, en_out, frame_done);
  modport slave  (input  enable, value, dp_in, load,
                  output out7, dp_out, en_out, frame_done);
endinterface

// File: rtl/seg7_scan_display_hex_decoder.sv
// Combinational nibble to active-high {g,f,e,d,c,b,a} segment pattern.
module seg7_hex_decoder
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  assign o_seg = hex_to_seg(i_nib);
endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed N-digit hex display driver with frame-boundary (tear-free) updates and
// per-slot ghost blanking. Optional SEG7_LEADING_ZERO_BLANK_EN darkens leading zero digits.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input logic               Clk,
  input logic               Reset,
  seg7_scan_display_if.slave bus
);
  localparam int   IDXW  = idx_width(NUM_DIGITS);
  localparam int   PRESW = $clog2(REFRESH_DIV);
  localparam logic L_OFF = off_level(ACTIVE_LOW);

  logic [PRESW-1:0]        r_presc;
  logic [IDXW-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_val, r_disp_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_disp_dp;
  logic                    r_frame_done;
  logic [6:0]              r_out7;
  logic                    r_dp_out;
  logic [NUM_DIGITS-1:0]   r_en_out;

  logic                    w_slot_end, w_last, w_boundary, w_lit;
  logic [4*NUM_DIGITS-1:0] w_next_val;
  logic [NUM_DIGITS-1:0]   w_next_dp, w_keep, w_en_h;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg;

  assign w_slot_end = (r_presc == PRESW'(REFRESH_DIV - 1));
  assign w_last     = (r_idx == IDXW'(NUM_DIGITS - 1));
  assign w_boundary = w_slot_end & w_last;
  // A load in the boundary cycle bypasses the pending register.
  assign w_next_val = bus.load ? bus.value : r_pend_val;
  assign w_next_dp  = bus.load ? bus.dp_in : r_pend_dp;
  assign w_nib      = r_disp_val[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic w_acc;
  always_comb begin
    w_keep = '0;
    w_acc  = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_acc     = w_acc | (r_disp_val[4*k +: 4] != 4'h0) | r_disp_dp[k];
      w_keep[k] = w_acc;
    end
    w_keep[0] = 1'b1;
  end
`else
  assign w_keep = '1;
`endif

  assign w_lit  = bus.enable && (r_presc >= PRESW'(BLANK_CYCLES)) && w_keep[r_idx];
  assign w_en_h = w_lit ? (NUM_DIGITS'(1) << r_idx) : '0;

  seg7_hex_decoder u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  // While disabled the display register follows pending, so re-enabling shows it at once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (bus.load) begin
        r_pend_val <= bus.value;
        r_pend_dp  <= bus.dp_in;
      end
      if (!bus.enable) begin
        r_presc      <= '0;
        r_idx        <= '0;
        r_frame_done <= 1'b0;
        r_disp_val   <= w_next_val;
        r_disp_dp    <= w_next_dp;
      end else begin
        r_frame_done <= w_boundary;
        if (w_slot_end) begin
          r_presc <= '0;
          r_idx   <= w_last ? '0 : r_idx + IDXW'(1);
        end else begin
          r_presc <= r_presc + PRESW'(1);
        end
        if (w_boundary) begin
          r_disp_val <= w_next_val;
          r_disp_dp  <= w_next_dp;
        end
      end
    end
  end

  // Pin polarity is applied here by XOR with the OFF level.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out7   <= seg_off(ACTIVE_LOW);
      r_dp_out <= L_OFF;
      r_en_out <= {NUM_DIGITS{L_OFF}};
    end else begin
      r_out7   <= (w_lit ? w_seg : 7'h00) ^ seg_off(ACTIVE_LOW);
      r_dp_out <= (w_lit & r_disp_dp[r_idx]) ^ L_OFF;
      r_en_out <= w_en_h ^ {NUM_DIGITS{L_OFF}};
    end
  end

  assign bus.out7       = r_out7;
  assign bus.dp_out     = r_dp_out;
  assign bus.en_out     = r_en_out;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display (4 digits, 4-cycle slots, 1 blank cycle, active-low pins).
module tb_seg7_scan_display;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  seg7_scan_display_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_display #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .ACTIVE_LOW   (1)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Active-low pin codes for 0..F, written from the digit shapes.
  logic [6:0] seg_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic bit shown(input int k, input logic [15:0] v, input logic [3:0] dp);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    int top = 0;
    for (int j = 0; j < ND; j++)
      if ((((v >> (4*j)) & 16'hF) != 16'h0) || dp[j]) top = j;
    return k <= top;
`else
    return 1'b1;
`endif
  endfunction

  // Model: a single enabled-cycle count gives slot and phase; outputs lag one cycle.
  int         run, slot, phase;
  bit         lit;
  logic [15:0] m_pend_v, m_disp_v;
  logic [3:0]  m_pend_dp, m_disp_dp;
  logic [6:0]  e_out7;
  logic        e_dp, e_fd;
  logic [3:0]  e_en;
  logic [3:0]  one = 4'b0001;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      run = 0; m_pend_v = 0; m_pend_dp = 0; m_disp_v = 0; m_disp_dp = 0;
      e_out7 = 7'h7F; e_dp = 1'b1; e_en = 4'hF; e_fd = 1'b0;
    end else begin
      if (bus.enable) begin
        slot   = (run / RD) % ND;
        phase  = run % RD;
        lit    = (phase >= BC) && shown(slot, m_disp_v, m_disp_dp);
        e_en   = lit ? ~(one << slot) : 4'hF;
        e_out7 = lit ? seg_al[m_disp_v[4*slot +: 4]] : 7'h7F;
        e_dp   = lit ? ~m_disp_dp[slot] : 1'b1;
        e_fd   = (run % (RD*ND)) == (RD*ND - 1);
        if (e_fd) begin
          m_disp_v  = bus.load ? bus.value : m_pend_v;
          m_disp_dp = bus.load ? bus.dp_in : m_pend_dp;
        end
        run++;
      end else begin
        e_out7 = 7'h7F; e_dp = 1'b1; e_en = 4'hF; e_fd = 1'b0; run = 0;
        m_disp_v  = bus.load ? bus.value : m_pend_v;
        m_disp_dp = bus.load ? bus.dp_in : m_pend_dp;
      end
      if (bus.load) begin
        m_pend_v  = bus.value;
        m_pend_dp = bus.dp_in;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_on) begin
      check("out7", bus.out7, e_out7);
      check("dp_out", bus.dp_out, e_dp);
      check("en_out", bus.en_out, e_en);
      check("frame_done", bus.frame_done, e_fd);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] dp);
    bus.value = v; bus.dp_in = dp; bus.load = 1'b1;
    @(negedge Clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_fd();
    int cyc = 0;
    while (bus.frame_done !== 1'b1 && cyc < 40) begin
      @(negedge Clk);
      cyc++;
    end
    check("fd_wait", bus.frame_done, 1'b1);
  endtask

  logic [3:0] exp_en2  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] exp_seg2 [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
  int pulses;

  initial begin
    bus.enable = 1'b0; bus.value = '0; bus.dp_in = '0; bus.load = 1'b0;
    #1 Reset = 1'b1;
    #1;
    check("rst_out7", bus.out7, 7'h7F);
    check("rst_dp", bus.dp_out, 1'b1);
    check("rst_en", bus.en_out, 4'hF);
    check("rst_fd", bus.frame_done, 1'b0);
    chk_on = 1'b1;
    step(2);
    #2 Reset = 1'b0;
    bus.enable = 1'b1;
    @(negedge Clk);

    // Scan of 12AF over one full frame
    load_word(16'h12AF, 4'h0);
    wait_fd();
    for (int k = 0; k < ND; k++) begin
      @(negedge Clk);
      check("slot_blank", bus.en_out, 4'hF);
      @(negedge Clk);
      check("slot_en", bus.en_out, exp_en2[k]);
      check("slot_seg", bus.out7, exp_seg2[k]);
      check("slot_dp", bus.dp_out, 1'b1);
      step(2);
    end
    check("fd_period", bus.frame_done, 1'b1);

    // frame_done cadence
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      if (bus.frame_done === 1'b1) pulses++;
    end
    check("fd_count", pulses, 4);

    // Tear-free update: mid-frame load, then boundary-cycle load wins
    step(5);
    load_word(16'h1111, 4'h0);
    check("old_mid", bus.out7, 7'h08);
    step(9);
    load_word(16'h2222, 4'h0);
    check("bnd_fd", bus.frame_done, 1'b1);
    check("old_tail", bus.out7, 7'h79);
    step(2);
    check("new_en", bus.en_out, 4'hE);
    check("new_seg", bus.out7, 7'h24);

    // Disable for 10 cycles with a load inside, then restart
    bus.enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin bus.value = 16'h5678; bus.dp_in = 4'h0; bus.load = 1'b1; end
      if (i == 4) bus.load = 1'b0;
      @(negedge Clk);
      check("dis_en", bus.en_out, 4'hF);
      if (bus.frame_done === 1'b1) pulses++;
    end
    check("dis_fd", pulses, 0);
    bus.enable = 1'b1;
    @(negedge Clk);
    check("restart_blank", bus.en_out, 4'hF);
    @(negedge Clk);
    check("restart_en", bus.en_out, 4'hE);
    check("restart_seg", bus.out7, 7'h00);

    // Reset asserted mid-scan
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_out7", bus.out7, 7'h7F);
    check("mid_rst_dp", bus.dp_out, 1'b1);
    check("mid_rst_en", bus.en_out, 4'hF);
    check("mid_rst_fd", bus.frame_done, 1'b0);
    @(negedge Clk);
    #2 Reset = 1'b0;
    @(negedge Clk);

    // Leading zero handling
    load_word(16'h0030, 4'h0);
    wait_fd();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    step(2);
    check("lz_d0_en", bus.en_out, 4'hE);
    check("lz_d0_seg", bus.out7, 7'h40);
    step(4);
    check("lz_d1_en", bus.en_out, 4'hD);
    check("lz_d1_seg", bus.out7, 7'h30);
    step(4);
    check("lz_d2_dark", bus.en_out, 4'hF);
    step(4);
    check("lz_d3_dark", bus.en_out, 4'hF);
    load_word(16'h0000, 4'h0);
    wait_fd();
    step(2);
    check("z_d0_en", bus.en_out, 4'hE);
    check("z_d0_seg", bus.out7, 7'h40);
    step(4);
    check("z_d1_dark", bus.en_out, 4'hF);
    step(2);
    load_word(16'h0000, 4'b0100);
    wait_fd();
    step(6);
    check("dp_d1_en", bus.en_out, 4'hD);
    step(4);
    check("dp_d2_en", bus.en_out, 4'hB);
    check("dp_d2_seg", bus.out7, 7'h40);
    check("dp_d2_dp", bus.dp_out, 1'b0);
`else
    step(10);
    check("lz_d2_en", bus.en_out, 4'hB);
    check("lz_d2_seg", bus.out7, 7'h40);
    step(4);
    check("lz_d3_en", bus.en_out, 4'h7);
    check("lz_d3_seg", bus.out7, 7'h40);
`endif
    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
